multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Parametrised multi-cycle control sequencer for the non-pipelined processor.
- Replaces the fixed three-state fetch sequencer with a five-phase instruction cycle: FETCH, DECODE, EXEC, MEM, WB.
- Adds req/ack handshakes to instruction and data memory, a configurable execute latency, a stall input, a memory-timeout error state and a retired-instruction counter.
- Sits between the memories/datapath and the processor top, and drives the enables of the datapath registers.

Parameters:
- EXEC_CYCLES, 1, cycles spent in EXEC per instruction (>=1).
- MEM_TIMEOUT, 16, max cycles waiting for dmem_ack before error (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  async, active-high.
- stall  in  1  freeze request from datapath; honoured only in DECODE, EXEC, WB.
- op_class  in  2  instruction class from decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write enable (store).
- fetch  out  1  high while in FETCH.
- decode  out  1  high while in DECODE.
- execute  out  1  high while in EXEC.
- ir_en  out  1  instruction register load strobe.
- rf_we  out  1  register-file write strobe.
- pc_en  out  1  PC update strobe (instruction retire).
- err  out  1  sticky memory-timeout error.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, ERR. Registered state; outputs are decoded combinationally from state, inputs and counters.
- Reset (asynchronous): state=FETCH, exec counter=0, timeout counter=0, latched op_class=0, retired=0, err=0.
  - While reset is held: imem_req=1, fetch=1; all other outputs 0.
- FETCH:
  - imem_req=1, fetch=1.
  - On imem_ack=1: ir_en=1 the same cycle; next state DECODE.
  - Otherwise wait indefinitely. stall is ignored.
- DECODE:
  - decode=1. op_class is latched into an internal register on the exit edge.
  - Next state EXEC unless stall=1, in which case hold.
- EXEC:
  - execute=1. Exec counter increments each non-stalled cycle.
  - When counter==EXEC_CYCLES-1 and stall=0, exit and clear the counter. Exit target depends on latched class:
    - ALU -> WB.
    - LOAD or STORE -> MEM.
    - BRANCH -> FETCH, with pc_en=1 that cycle.
  - stall=1 freezes both counter and state.
- MEM:
  - dmem_req=1; dmem_we=1 iff latched class is STORE.
  - Timeout counter increments each cycle without ack.
  - On dmem_ack=1: clear timeout counter. LOAD -> WB; STORE -> FETCH with pc_en=1 that cycle.
  - If counter reaches MEM_TIMEOUT-1 with no ack: next state ERR.
  - An ack arriving in the same cycle as the timeout wins (no error).
  - stall is ignored.
- WB:
  - If stall=0: rf_we=1 and pc_en=1 for one cycle; next state FETCH.
  - If stall=1: rf_we=0, pc_en=0, hold.
- ERR:
  - err=1. All request and strobe outputs are 0.
  - Exit only via reset.
- Retired counter: retired increments by 1 on every cycle with pc_en=1 and wraps modulo 2^CNT_W.
- Strobes: ir_en, rf_we and pc_en are single-cycle pulses, never asserted together.
- Reset mid-instruction: returns immediately to the FETCH reset state. Any in-flight memory request is dropped, and no pc_en or rf_we is issued.
- Stray acks: imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Minimum instruction latency with immediate acks and EXEC_CYCLES=1:
  - BRANCH 3 cycles.
  - ALU 4 cycles.
  - STORE 4 cycles.
  - LOAD 5 cycles.

Test Plan:
- ALU, EXEC_CYCLES=1, imem_ack tied high, no stall -> state sequence FETCH, DECODE, EXEC, WB repeating. ir_en, rf_we and pc_en each pulse once per 4 cycles. retired=3 after 12 cycles.
- LOAD, EXEC_CYCLES=3, dmem_ack 2 cycles after MEM entry -> execute high 3 cycles, dmem_req high 3 cycles with dmem_we=0, then WB with rf_we=1. Total 9 cycles per instruction.
- STORE followed by BRANCH -> STORE shows dmem_we=1 in MEM, pc_en on MEM exit, rf_we never asserted. BRANCH shows pc_en on EXEC exit with no MEM/WB. retired=2.
- MEM_TIMEOUT=4, LOAD with dmem_ack held low -> after 4 MEM cycles state=ERR and err=1 stays 1. imem_req=0 afterwards. Reset restores err=0 and state FETCH.
- stall=1 for 5 cycles during EXEC (EXEC_CYCLES=2), then for 2 cycles in WB -> EXEC lasts 7 cycles and WB 3. rf_we/pc_en pulse only after stall drops. stall asserted during FETCH has no effect.
- CNT_W=4, 17 BRANCH instructions -> retired wraps to 1. Reset asserted in MEM mid-LOAD -> outputs return to reset values asynchronously, no rf_we issued.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: five-phase (FETCH/DECODE/EXEC/MEM/WB) instruction sequencer with memory handshakes
// Inputs : clk, reset (async, active-high), stall, op_class[1:0], imem_ack, dmem_ack
// Outputs: imem_req, dmem_req, dmem_we, fetch, decode, execute, ir_en, rf_we, pc_en, err, retired[CNT_W-1:0]
module multicycle_ctrl_fsm #(
  parameter int EXEC_CYCLES = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       op_class,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             fetch,
  output logic             decode,
  output logic             execute,
  output logic             ir_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic             err,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;
  localparam int EW = $clog2(EXEC_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0] ALU = 2'd0, STORE = 2'd2, BRANCH = 2'd3;
  state_t state_q, state_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0] cls_q, cls_d;
  logic [CNT_W-1:0] retired_q;
  always_comb begin
    state_d = state_q;
    ecnt_d = ecnt_q;
    tcnt_d = tcnt_q;
    cls_d = cls_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    fetch = 1'b0;
    decode = 1'b0;
    execute = 1'b0;
    ir_en = 1'b0;
    rf_we = 1'b0;
    pc_en = 1'b0;
    err = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        fetch = 1'b1;
        // the strobe is combinational on ack, so mask it while reset is held
        ir_en = imem_ack & ~reset;
        state_d = imem_ack ? DECODE : FETCH;
      end
      DECODE: begin
        decode = 1'b1;
        if (!stall) begin
          state_d = EXEC;
          cls_d = op_class;
        end
      end
      EXEC: begin
        execute = 1'b1;
        if (!stall) begin
          if (ecnt_q == EW'(EXEC_CYCLES - 1)) begin
            ecnt_d = '0;
            state_d = cls_q == ALU ? WB : cls_q == BRANCH ? FETCH : MEM;
            pc_en = cls_q == BRANCH;
          end else begin
            ecnt_d = ecnt_q + 1'b1;
          end
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = cls_q == STORE;
        // an ack on the timeout cycle still completes the access
        if (dmem_ack) begin
          tcnt_d = '0;
          state_d = cls_q == STORE ? FETCH : WB;
          pc_en = cls_q == STORE;
        end else if (tcnt_q == TW'(MEM_TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WB: begin
        rf_we = ~stall;
        pc_en = ~stall;
        state_d = stall ? WB : FETCH;
      end
      ERR: err = 1'b1;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ecnt_q <= '0;
      tcnt_q <= '0;
      cls_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ecnt_q <= ecnt_d;
      tcnt_q <= tcnt_d;
      cls_q <= cls_d;
      retired_q <= retired_q + CNT_W'(pc_en);
    end
  end
  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized and scenario bench for multicycle_ctrl_fsm against a phase-level model
module tb_multicycle_ctrl_fsm;
  localparam int EC = 2, TO = 4, CW = 4;
  logic clk = 0, reset = 1, stall = 0, imem_ack = 0, dmem_ack = 0;
  logic [1:0] op_class = 0;
  logic imem_req, dmem_req, dmem_we, fetch, decode, execute, ir_en, rf_we, pc_en, err;
  logic [CW-1:0] retired;
  int n_cmp = 0, n_fail = 0;
  multicycle_ctrl_fsm #(.EXEC_CYCLES(EC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .op_class(op_class), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .fetch(fetch), .decode(decode),
    .execute(execute), .ir_en(ir_en), .rf_we(rf_we), .pc_en(pc_en), .err(err), .retired(retired)
  );
  always #5 clk = ~clk;
  wire [9:0] outs = {imem_req, dmem_req, dmem_we, fetch, decode, execute, ir_en, rf_we, pc_en, err};
  localparam logic [9:0] RST_OUTS = 10'h240;
  // phase: 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 error
  int ph, left, waited, ret;
  logic [1:0] cls;
  logic e_pc;
  logic [9:0] exp_o;
  always_comb begin
    e_pc = (ph == 4 && !stall) || (ph == 2 && !stall && left == 1 && cls == 2'd3) || (ph == 3 && dmem_ack && cls == 2'd2);
    exp_o = {ph == 0, ph == 3, ph == 3 && cls == 2'd2, ph == 0, ph == 1, ph == 2,
             ph == 0 && imem_ack && !reset, ph == 4 && !stall, e_pc, ph == 5};
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph <= 0; left <= 0; waited <= 0; cls <= 0; ret <= 0;
    end else begin
      ret <= (ret + int'(e_pc)) % (1 << CW);
      case (ph)
        0: if (imem_ack) ph <= 1;
        1: if (!stall) begin ph <= 2; cls <= op_class; left <= EC; end
        2: if (!stall) begin
             if (left == 1) begin ph <= cls == 2'd0 ? 4 : cls == 2'd3 ? 0 : 3; waited <= 0; end
             else left <= left - 1;
           end
        3: if (dmem_ack) ph <= cls == 2'd2 ? 0 : 4;
           else if (waited == TO - 1) ph <= 5;
           else waited <= waited + 1;
        4: if (!stall) ph <= 0;
        default: ;
      endcase
    end
  end
  task automatic rst_pulse();
    reset = 1; stall = 0; imem_ack = 0; dmem_ack = 0; op_class = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask
  task automatic test_reset();
    reset = 1; imem_ack = 1; stall = 1; dmem_ack = 1; op_class = 3;
    #2;
    n_cmp++;
    if (outs !== RST_OUTS || retired !== 0) begin n_fail++; $display("FAIL reset_async: outs=%b ret=%0d exp %b 0", outs, retired, RST_OUTS); end
    @(posedge clk); #1;
    n_cmp++;
    if (outs !== RST_OUTS || retired !== 0) begin n_fail++; $display("FAIL reset_held: outs=%b ret=%0d exp %b 0", outs, retired, RST_OUTS); end
    imem_ack = 0; stall = 0; dmem_ack = 0;
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== RST_OUTS) begin n_fail++; $display("FAIL reset_release: outs=%b exp %b", outs, RST_OUTS); end
    @(posedge clk); #1;
  endtask
  task automatic test_alu();
    int nir = 0, nrf = 0, npc = 0;
    rst_pulse();
    op_class = 0; imem_ack = 1;
    for (int c = 0; c < 3 * (3 + EC); c++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o || retired !== CW'(ret)) begin n_fail++; $display("FAIL alu_model c%0d: outs=%b ret=%0d exp %b %0d", c, outs, retired, exp_o, ret); end
      nir += int'(ir_en); nrf += int'(rf_we); npc += int'(pc_en);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nir !== 3 || nrf !== 3 || npc !== 3 || retired !== 3) begin
      n_fail++; $display("FAIL alu_counts: ir=%0d rf=%0d pc=%0d ret=%0d exp 3 3 3 3", nir, nrf, npc, retired);
    end
  endtask
  task automatic test_load();
    int mc = 0, ne = 0, nwe = 0, nrf = 0, cyc = 0;
    bit done = 0;
    rst_pulse();
    op_class = 1; imem_ack = 1;
    while (!done && cyc < 60) begin
      dmem_ack = dmem_req && mc == 2;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o || retired !== CW'(ret)) begin n_fail++; $display("FAIL load_model c%0d: outs=%b ret=%0d exp %b %0d", cyc, outs, retired, exp_o, ret); end
      mc += int'(dmem_req); ne += int'(execute); nwe += int'(dmem_we); nrf += int'(rf_we);
      done = pc_en;
      @(posedge clk); #1;
      cyc++;
    end
    dmem_ack = 0;
    n_cmp++;
    if (!done || cyc !== 6 + EC || ne !== EC || mc !== 3 || nwe !== 0 || nrf !== 1) begin
      n_fail++; $display("FAIL load_timing: done=%0d cyc=%0d exe=%0d req=%0d we=%0d rf=%0d exp 1 %0d %0d 3 0 1", done, cyc, ne, mc, nwe, nrf, 6 + EC, EC);
    end
  endtask
  task automatic test_store_branch();
    int npc = 0, nrf = 0, nwe = 0, nreq = 0, cyc = 0;
    rst_pulse();
    imem_ack = 1; dmem_ack = 1;
    while (npc < 2 && cyc < 60) begin
      op_class = npc == 0 ? 2'd2 : 2'd3;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o || retired !== CW'(ret)) begin n_fail++; $display("FAIL stbr_model c%0d: outs=%b ret=%0d exp %b %0d", cyc, outs, retired, exp_o, ret); end
      npc += int'(pc_en); nrf += int'(rf_we); nwe += int'(dmem_we); nreq += int'(dmem_req);
      @(posedge clk); #1;
      cyc++;
    end
    dmem_ack = 0;
    n_cmp++;
    if (cyc !== 5 + 2 * EC || nrf !== 0 || nwe !== 1 || nreq !== 1 || retired !== 2) begin
      n_fail++; $display("FAIL stbr_counts: cyc=%0d rf=%0d we=%0d req=%0d ret=%0d exp %0d 0 1 1 2", cyc, nrf, nwe, nreq, retired, 5 + 2 * EC);
    end
  endtask
  task automatic test_timeout();
    int nreq = 0, cyc = 0;
    rst_pulse();
    op_class = 1; imem_ack = 1; dmem_ack = 0;
    while (!err && cyc < 60) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o) begin n_fail++; $display("FAIL tmo_model c%0d: outs=%b exp %b", cyc, outs, exp_o); end
      nreq += int'(dmem_req);
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (!err || nreq !== TO) begin n_fail++; $display("FAIL tmo_entry: err=%0d mem_cycles=%0d exp 1 %0d", err, nreq, TO); end
    dmem_ack = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (err !== 1 || imem_req !== 0 || outs !== exp_o) begin n_fail++; $display("FAIL tmo_sticky c%0d: outs=%b exp %b", c, outs, exp_o); end
      @(posedge clk); #1;
    end
    dmem_ack = 0;
    reset = 1;
    #1;
    n_cmp++;
    if (err !== 0 || outs !== RST_OUTS) begin n_fail++; $display("FAIL tmo_reset: outs=%b exp %b", outs, RST_OUTS); end
    @(posedge clk); #1;
    reset = 0;
  endtask
  task automatic test_stall();
    int se = 0, sw = 0, ne = 0, nw = 0, nf = 0, nrf = 0, cyc = 0;
    bit done = 0, in_wb;
    rst_pulse();
    op_class = 0; imem_ack = 1;
    while (!done && cyc < 60) begin
      in_wb = !(fetch || decode || execute || dmem_req || err);
      stall = fetch || (execute && se < 5) || (in_wb && sw < 2);
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o || retired !== CW'(ret)) begin n_fail++; $display("FAIL stall_model c%0d: outs=%b ret=%0d exp %b %0d", cyc, outs, retired, exp_o, ret); end
      se += int'(execute && stall); sw += int'(in_wb && stall);
      ne += int'(execute); nw += int'(in_wb); nf += int'(fetch); nrf += int'(rf_we);
      done = pc_en;
      @(posedge clk); #1;
      cyc++;
    end
    stall = 0;
    n_cmp++;
    if (cyc !== EC + 10 || ne !== EC + 5 || nw !== 3 || nf !== 1 || nrf !== 1) begin
      n_fail++; $display("FAIL stall_timing: cyc=%0d exe=%0d wb=%0d fetch=%0d rf=%0d exp %0d %0d 3 1 1", cyc, ne, nw, nf, nrf, EC + 10, EC + 5);
    end
  endtask
  task automatic test_wrap();
    int npc = 0;
    rst_pulse();
    op_class = 3; imem_ack = 1;
    for (int c = 0; c < 17 * (2 + EC); c++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o || retired !== CW'(ret)) begin n_fail++; $display("FAIL wrap_model c%0d: outs=%b ret=%0d exp %b %0d", c, outs, retired, exp_o, ret); end
      npc += int'(pc_en);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (npc !== 17 || retired !== 1) begin n_fail++; $display("FAIL wrap_count: pc=%0d ret=%0d exp 17 1", npc, retired); end
  endtask
  task automatic test_reset_mid();
    int cyc = 0, nrf = 0;
    rst_pulse();
    op_class = 1; imem_ack = 1; dmem_ack = 0;
    while (!dmem_req && cyc < 20) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o) begin n_fail++; $display("FAIL rmid_model c%0d: outs=%b exp %b", cyc, outs, exp_o); end
      nrf += int'(rf_we);
      @(posedge clk); #1;
      cyc++;
    end
    #2;
    reset = 1;
    #1;
    n_cmp++;
    if (outs !== RST_OUTS || outs !== exp_o || retired !== 0 || nrf !== 0 || cyc !== 2 + EC) begin
      n_fail++; $display("FAIL rmid_reset: outs=%b ret=%0d rf=%0d cyc=%0d exp %b 0 0 %0d", outs, retired, nrf, cyc, RST_OUTS, 2 + EC);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask
  task automatic test_random();
    rst_pulse();
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 199) == 0;
      stall = $urandom_range(0, 3) == 0;
      op_class = 2'($urandom);
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = $urandom_range(0, 2) == 0;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_o || retired !== CW'(ret)) begin n_fail++; $display("FAIL rand_model c%0d: outs=%b ret=%0d exp %b %0d", c, outs, retired, exp_o, ret); end
      @(posedge clk); #1;
    end
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_timeout();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
